// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// fault codes and the instruction word width.
package ifetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_VALID = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  // A fetch address is usable only when word aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Wait counter for an outstanding instruction fetch; expire flags the
// last cycle the fetch may wait before being declared timed out.
module fetch_wdog #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  // Count waiting cycles; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one memory read per instruction, buffers
// the returned word for decode, and traps timeouts and misaligned PCs.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned RESET_HOLD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] pc_in,
  output logic               pc_hold,
  input  logic               flush,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic [INSTR_W-1:0] ir_pc,
  output logic [INSTR_W-1:0] ir_pc4,
  output logic               fetch_err,
  output logic [1:0]         err_code
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  err_nxt;
  logic        latch;
  logic        aligned;
  logic        expire;
  logic        hold_done;
  logic [15:0] hold_cnt;

  assign aligned   = is_aligned(pc_in[1:0]);
  assign hold_done = ({16'd0, hold_cnt} + 32'd1) >= RESET_HOLD;

  fetch_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush || (state != ST_REQ)),
    .enable (state == ST_REQ),
    .expire (expire)
  );

  // Next-state decode; flush overrides every other condition.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    latch     = 1'b0;
    if (flush) begin
      state_nxt = ST_REQ;
      err_nxt   = ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hold_done) state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (!aligned) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_MISALIGN;
          end else if (mem_ack) begin
            state_nxt = ST_VALID;
            latch     = 1'b1;
          end else if (expire) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_TIMEOUT;
          end
        end
        ST_VALID: begin
          if (ir_ready) state_nxt = ST_REQ;
        end
        default: ;
      endcase
    end
  end

  // State and fault code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
    end
  end

  // Post-reset hold counter, only advances while idling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE && !hold_done) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  // Instruction buffer, loaded on an accepted memory acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_out <= '0;
      ir_pc  <= '0;
      ir_pc4 <= '0;
    end else if (latch) begin
      ir_out <= mem_rdata;
      ir_pc  <= pc_in;
      ir_pc4 <= pc_in + 32'd4;
    end
  end

  assign mem_addr  = pc_in;
  assign mem_req   = (state == ST_REQ) && aligned;
  assign ir_valid  = (state == ST_VALID);
  assign fetch_err = (state == ST_ERR);
  assign pc_hold   = rst || !(flush || ((state == ST_VALID) && ir_ready));

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: PC register and memory models drive
// the DUT; every acknowledged fetch pushes its expected instruction into a
// scoreboard that a separate monitor pops when decode accepts it.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc4;
  logic        fetch_err;
  logic [1:0]  err_code;

  ifetch_unit #(
    .TIMEOUT_CYC (16),
    .RESET_HOLD  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_hold   (pc_hold),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc),
    .ir_pc4    (ir_pc4),
    .fetch_err (fetch_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          active = 1'b0;

  // Environment knobs
  logic [31:0] pc_reg;
  int unsigned lat_cfg;
  int unsigned waited;
  bit          ready_rand;
  bit          ready_val;
  bit          spurious_ok;
  bit          flush_now;
  logic [31:0] flush_tgt;

  // Memory contents: address 0 holds 0x20080005.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h20080005;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of environment activity: PC register, memory, decode.
  task automatic cycle();
    @(negedge clk);
    pc_in    = pc_reg;
    flush    = flush_now;
    ir_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_val;
    #1;
    if (mem_req) begin
      if (waited >= lat_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = memf(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        waited++;
      end
    end else begin
      waited    = 0;
      mem_ack   = spurious_ok && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
    #2;
    if (flush) begin
      sb.delete();
      pc_reg = flush_tgt;
      waited = 0;
    end else begin
      if (mem_req && mem_ack) begin
        sb.push_back('{pc_reg, memf(pc_reg)});
        waited = 0;
      end
      if (!pc_hold) pc_reg = pc_reg + 32'd4;
    end
    flush_now = 1'b0;
  endtask

  task automatic run_until_valid(input int unsigned max, input string nm);
    int unsigned n = 0;
    do begin
      cycle();
      n++;
    end while (!ir_valid && n < max);
    if (!ir_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no ir_valid within %0d cycles", nm, max);
    end
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_now = 1'b1;
    flush_tgt = tgt;
    cycle();
  endtask

  // Monitor: compares the buffered instruction against the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (active && !rst) begin
      chk("ir_valid_vs_sb", 32'(ir_valid), 32'(sb.size() != 0));
      chk("pc_hold_rule", 32'(pc_hold), 32'(!(flush || (ir_valid && ir_ready))));
      if (ir_valid) chk("no_req_in_valid", 32'(mem_req), 32'd0);
      if (ir_valid && sb.size() != 0) begin
        chk("ir_out", ir_out, sb[0].ins);
        chk("ir_pc", ir_pc, sb[0].pc);
        chk("ir_pc4", ir_pc4, sb[0].pc + 32'd4);
        if (ir_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned vidx[$];
    logic [31:0] vpc[$];
    int unsigned n_req;
    logic [31:0] t;

    rst = 1'b1; pc_in = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; pc_reg = '0; lat_cfg = 2; waited = 0;
    ready_rand = 1'b0; ready_val = 1'b0; spurious_ok = 1'b0;
    flush_now = 1'b0; flush_tgt = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_ir_pc", ir_pc, 32'd0);
    chk("rst_ir_pc4", ir_pc4, 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_pc_hold", 32'(pc_hold), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    active = 1'b1;

    // First fetch with two wait cycles, then a five-cycle decode stall
    cycle();
    chk("idle_no_req", 32'(mem_req), 32'd0);
    run_until_valid(20, "first_fetch");
    chk("first_ir_out", ir_out, 32'h20080005);
    chk("first_ir_pc", ir_pc, 32'h0);
    chk("first_ir_pc4", ir_pc4, 32'h4);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_ir_out", ir_out, 32'h20080005);
      chk("stall_pc_hold", 32'(pc_hold), 32'd1);
      chk("stall_mem_req", 32'(mem_req), 32'd0);
      chk("stall_ir_valid", 32'(ir_valid), 32'd1);
    end
    ready_val = 1'b1;
    cycle();
    chk("accept_pc_hold", 32'(pc_hold), 32'd0);
    ready_val = 1'b0;
    cycle();
    chk("after_accept_pc_hold", 32'(pc_hold), 32'd1);

    // Back-to-back zero-wait fetches from address 0
    ready_val = 1'b1;
    lat_cfg = 0;
    do_flush(32'h0);
    for (int unsigned i = 0; i < 8; i++) begin
      cycle();
      if (ir_valid) begin
        vidx.push_back(i);
        vpc.push_back(ir_pc);
      end
    end
    chk("b2b_count", 32'(vidx.size()), 32'd4);
    for (int unsigned k = 0; k < vidx.size() && k < 4; k++) begin
      chk("b2b_slot", vidx[k], 2 * k + 1);
      chk("b2b_pc", vpc[k], 4 * k);
    end

    // Timeout: memory never answers
    lat_cfg = 1000;
    do_flush(32'h40);
    n_req = 0;
    for (int i = 0; i < 40 && !fetch_err; i++) begin
      cycle();
      if (mem_req) n_req++;
    end
    chk("timeout_req_cycles", n_req, 32'd16);
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("timeout_code", 32'(err_code), 32'd1);
    chk("timeout_mem_req", 32'(mem_req), 32'd0);
    chk("timeout_pc_hold", 32'(pc_hold), 32'd1);
    spurious_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("err_sticky", 32'(fetch_err), 32'd1);
      chk("err_ir_valid", 32'(ir_valid), 32'd0);
    end
    spurious_ok = 1'b0;
    lat_cfg = 1;
    do_flush(32'h100);
    cycle();
    chk("recover_err", 32'(fetch_err), 32'd0);
    chk("recover_code", 32'(err_code), 32'd0);
    chk("recover_req", 32'(mem_req), 32'd1);
    chk("recover_addr", mem_addr, 32'h100);
    run_until_valid(10, "recover_fetch");
    chk("recover_ir_pc", ir_pc, 32'h100);

    // Misaligned redirect target
    do_flush(32'h6);
    cycle();
    chk("misalign_no_req", 32'(mem_req), 32'd0);
    cycle();
    chk("misalign_err", 32'(fetch_err), 32'd1);
    chk("misalign_code", 32'(err_code), 32'd2);

    // Flush in the same cycle as an acknowledge
    lat_cfg = 0;
    do_flush(32'h200);
    chk("pre_ack_req", 32'(mem_req), 32'd0);
    flush_now = 1'b1;
    flush_tgt = 32'h300;
    cycle();
    chk("flush_ack_seen", 32'(mem_ack && mem_req), 32'd1);
    cycle();
    chk("flush_ack_discard", 32'(ir_valid), 32'd0);
    chk("refetch_addr", mem_addr, 32'h300);
    run_until_valid(10, "refetch");
    chk("refetch_ir_pc", ir_pc, 32'h300);
    chk("refetch_ir_out", ir_out, memf(32'h300));

    // Address wrap of ir_pc4
    do_flush(32'hFFFFFFFC);
    run_until_valid(10, "wrap_fetch");
    chk("wrap_ir_pc4", ir_pc4, 32'h0);

    // Randomised traffic
    ready_rand = 1'b1;
    spurious_ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      lat_cfg = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        t = $urandom;
        t[1:0] = 2'b00;
        if ($urandom_range(0, 4) == 0) t = 32'hFFFFFFFC;
        flush_now = 1'b1;
        flush_tgt = t;
      end
      cycle();
      chk("rand_no_err", 32'(fetch_err), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: REQ-state cycles without mem_ack before the timeout fault is raised (range 2..255).
REQ-002 Parameter RESET_HOLD, default 1: IDLE cycles after reset release before the first request.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port pc_in, input, 32: fetch address from the PC register.
REQ-006 Port pc_hold, output, 1: PC register enable inverse; 1 means the PC holds its value.
REQ-007 Port flush, input, 1: redirect; discard in-flight fetch and buffered instruction.
REQ-008 Port mem_req, output, 1: instruction memory read request.
REQ-009 Port mem_addr, output, 32: read address, valid while mem_req=1.
REQ-010 Port mem_ack, input, 1: read data valid on mem_rdata this cycle.
REQ-011 Port mem_rdata, input, 32: instruction word.
REQ-012 Port ir_valid, output, 1: buffered instruction available to decode.
REQ-013 Port ir_ready, input, 1: decode accepts the instruction.
REQ-014 Port ir_out, output, 32: buffered instruction word.
REQ-015 Port ir_pc, output, 32: address of ir_out.
REQ-016 Port ir_pc4, output, 32: ir_pc+4.
REQ-017 Port fetch_err, output, 1: sticky fault flag.
REQ-018 Port err_code, output, 2: 01 = timeout, 10 = misaligned pc_in; 00 = no fault.

Function
REQ-019 FSM states: IDLE, REQ, VALID, ERR.
REQ-020 IDLE: pc_hold=1, mem_req=0; after RESET_HOLD cycles, move to REQ.
REQ-021 REQ: pc_hold=1; mem_addr=pc_in (combinational); mem_req=1 if pc_in[1:0]=00.
REQ-022 In REQ with pc_in[1:0]!=00, no request is issued; next state ERR, err_code=10.
REQ-023 In REQ with mem_ack=1, latch ir_out=mem_rdata and ir_pc=pc_in; next state VALID. Result: ir_valid=1 in the cycle after the ack.
REQ-024 In REQ, the wait counter increments each cycle without ack. At count TIMEOUT_CYC-1 without ack, next state ERR with err_code=01. The counter clears on entry to REQ.
REQ-025 VALID: ir_valid=1, mem_req=0. When ir_ready=1: pc_hold=0 for that cycle only and next state REQ. Otherwise pc_hold=1 and ir_out/ir_pc stay stable.
REQ-026 ir_pc4 = ir_pc + 4, modulo 2^32; 0xFFFFFFFC yields 0x00000000.
REQ-027 Throughput: with zero-wait memory and ir_ready=1, one instruction every 2 cycles.
REQ-028 flush=1 in any state:
  - pc_hold=0 that cycle, so the PC loads the redirect target.
  - An ack in the same cycle is discarded.
  - Next state REQ; ir_valid=0 from the next cycle.
  - fetch_err and err_code clear.
REQ-029 flush has priority over mem_ack, ir_ready, timeout and misalignment in the same cycle.
REQ-030 ERR: mem_req=0, ir_valid=0, pc_hold=1, fetch_err=1; leaves only on flush or rst.
REQ-031 A late mem_ack arriving in IDLE, VALID or ERR is ignored.

Reset
REQ-032 On rst=1, asynchronously set: state IDLE, mem_req=0, ir_valid=0, ir_out=0, ir_pc=0, ir_pc4=0, fetch_err=0, err_code=00, pc_hold=1, wait counter 0.
REQ-033 rst asserted mid-fetch abandons the request immediately; memory must tolerate a dropped mem_req.

Structure
REQ-034 The shared package holds: FSM state encoding, err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_MISALIGN), and INSTR_W=32.
REQ-035 Sub-module fetch_wdog holds the wait counter, with inputs clear/enable and output expire.

Verification
REQ-036 Reset release, pc_in=0x00000000, mem_ack 2 cycles after mem_req, rdata=0x20080005 -> ir_out=0x20080005, ir_pc=0, ir_pc4=4, pc_hold=0 only on the ir_ready cycle.
REQ-037 Back-to-back fetches, zero-wait ack, ir_ready=1 -> ir_valid every 2nd cycle at addresses 0,4,8,12.
REQ-038 ir_ready=0 for 5 cycles in VALID -> ir_out stable, pc_hold=1, mem_req=0 throughout.
REQ-039 No ack for 16 cycles -> fetch_err=1, err_code=01, mem_req=0; then flush with pc_in=0x100 -> fetch resumes at 0x100 and error clears.
REQ-040 pc_in=0x00000006 -> no mem_req, err_code=10. Separately: flush coinciding with mem_ack -> data discarded and refetch from the new pc_in.
